// File: rtl/s2p_pkg.sv
// Shared constants and types for the s2p_rx serial receiver.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package s2p_pkg;

  // Default serial word length per channel.
  localparam int DATA_W_DEF = 16;

  // Receiver FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // The bit counter must be able to hold values 0..DATA_W.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DATA_W_DEF);

endpackage

// File: rtl/s2p_shift.sv
// Single-channel MSB-first shifter; word_o is the word completed by the current bit.
// Latency: word_o is combinational from the stored bits and the live serial input.
// Backpressure: none; advances only when en_i is high, holds otherwise.
module s2p_shift
  import s2p_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              SCLK,
  input  logic              CLR,
  input  logic              en_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              sdin_i,
  output logic [DATA_W-1:0] word_o
);

  // Only the DATA_W-1 bits received before the current one need storing;
  // the final bit is taken live from sdin_i when the word completes.
  logic [DATA_W-2:0] shift_q;
  logic [DATA_W-2:0] shift_d;

  assign word_o = {shift_q, sdin_i};

  // Start loads the MSB into a cleared register; later bits shift in at the LSB.
  always_comb begin
    shift_d = shift_q;
    if (en_i) begin
      if (load_i) begin
        shift_d    = '0;
        shift_d[0] = sdin_i;
      end else if (shift_i) begin
        shift_d = word_o[DATA_W-2:0];
      end
    end
  end

  // Shift register state.
  always_ff @(posedge SCLK or posedge CLR) begin
    if (CLR) shift_q <= '0;
    else     shift_q <= shift_d;
  end

endmodule

// File: rtl/s2p_rx.sv
// Two-channel framed serial-to-parallel receiver with a one-deep output holding register.
// Latency: word visible DATA_W EN-cycles after the FRAME start cycle.
// Backpressure: a word completing while the holder is full and un-ACKed is dropped; OVERRUN sticks.
module s2p_rx
  import s2p_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              SCLK,
  input  logic              CLR,
  input  logic              EN,
  input  logic              FRAME,
  input  logic              SDIN_L,
  input  logic              SDIN_R,
  input  logic              ACK,
  output logic [DATA_W-1:0] PDATA_L,
  output logic [DATA_W-1:0] PDATA_R,
  output logic              InReady,
  output logic              BUSY,
  output logic              OVERRUN
);

  localparam int               CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              frame_d_q;
  logic              busy_q;
  logic [DATA_W-1:0] pdata_l_q;
  logic [DATA_W-1:0] pdata_r_q;
  logic              inready_q;
  logic              overrun_q;

  logic              start;
  logic              shifting;
  logic              complete;
  logic [DATA_W-1:0] word_l;
  logic [DATA_W-1:0] word_r;

  // Start needs a sampled-low FRAME before the high, and is ignored mid-word.
  assign start    = EN && FRAME && !frame_d_q && (state_q == IDLE);
  assign shifting = EN && (state_q == RECV);
  assign complete = shifting && (cnt_q == LAST);

  s2p_shift #(.DATA_W(DATA_W)) u_shift_l (
    .SCLK    (SCLK),
    .CLR     (CLR),
    .en_i    (EN),
    .load_i  (start),
    .shift_i (shifting),
    .sdin_i  (SDIN_L),
    .word_o  (word_l)
  );

  s2p_shift #(.DATA_W(DATA_W)) u_shift_r (
    .SCLK    (SCLK),
    .CLR     (CLR),
    .en_i    (EN),
    .load_i  (start),
    .shift_i (shifting),
    .sdin_i  (SDIN_R),
    .word_o  (word_r)
  );

  // Frame edge history, FSM and bit counter; everything here freezes when EN=0.
  always_ff @(posedge SCLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      frame_d_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (EN) begin
      frame_d_q <= FRAME;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RECV;
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
          end
        end
        RECV: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register and handshake; ACK is honoured regardless of EN.
  always_ff @(posedge SCLK or posedge CLR) begin
    if (CLR) begin
      pdata_l_q <= '0;
      pdata_r_q <= '0;
      inready_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (complete) begin
      if (!inready_q || ACK) begin
        pdata_l_q <= word_l;
        pdata_r_q <= word_r;
        inready_q <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (ACK && inready_q) begin
      inready_q <= 1'b0;
    end
  end

  assign PDATA_L = pdata_l_q;
  assign PDATA_R = pdata_r_q;
  assign InReady = inready_q;
  assign BUSY    = busy_q;
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_s2p_rx.sv
// Directed bench for s2p_rx with a scoreboard of expected held words.
// Latency: inputs driven 1 time unit after each rising SCLK edge, outputs sampled there too.
// Backpressure: ACK driven explicitly by each step.
module tb_s2p_rx;

  logic        SCLK = 1'b0;
  logic        CLR;
  logic        EN;
  logic        FRAME;
  logic        SDIN_L;
  logic        SDIN_R;
  logic        ACK;
  logic [15:0] PDATA_L;
  logic [15:0] PDATA_R;
  logic        InReady;
  logic        BUSY;
  logic        OVERRUN;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb_q[$];

  always #5 SCLK = ~SCLK;

  s2p_rx #(.DATA_W(16)) dut (
    .SCLK    (SCLK),
    .CLR     (CLR),
    .EN      (EN),
    .FRAME   (FRAME),
    .SDIN_L  (SDIN_L),
    .SDIN_R  (SDIN_R),
    .ACK     (ACK),
    .PDATA_L (PDATA_L),
    .PDATA_R (PDATA_R),
    .InReady (InReady),
    .BUSY    (BUSY),
    .OVERRUN (OVERRUN)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge SCLK);
    #1;
  endtask

  // Compare the held pair against the oldest expected pair.
  task automatic chk_pop(input string tag);
    logic [31:0] exp;
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      chk({tag, "_pdata"}, {PDATA_L, PDATA_R}, exp);
    end
  endtask

  // Send one 16-bit pair with a FRAME pulse on bit 0. Optional EN=0 gap after
  // every bit but the last, optional ACK in the completion cycle.
  task automatic send_word(input logic [15:0] l, input logic [15:0] r,
                           input bit throttle, input bit ack_last,
                           input bit keep, input bit ir_empty);
    for (int i = 0; i < 16; i++) begin
      EN     = 1'b1;
      FRAME  = (i == 0);
      SDIN_L = l[15-i];
      SDIN_R = r[15-i];
      ACK    = ack_last && (i == 15);
      if (ir_empty && i == 15) chk("inready_before_done", 32'(InReady), 32'd0);
      tick;
      ACK = 1'b0;
      if (i < 15) chk($sformatf("busy_bit%0d", i), 32'(BUSY), 32'd1);
      if (throttle && i < 15) begin
        EN     = 1'b0;
        FRAME  = 1'b1;
        SDIN_L = ~SDIN_L;
        SDIN_R = ~SDIN_R;
        tick;
      end
    end
    EN     = 1'b1;
    FRAME  = 1'b0;
    SDIN_L = 1'b0;
    SDIN_R = 1'b0;
    chk("busy_after_word", 32'(BUSY), 32'd0);
    if (keep) sb_q.push_back({l, r});
  endtask

  initial begin
    logic        busy_seen;
    logic [15:0] vl;
    logic [15:0] vr;

    CLR = 1'b1; EN = 1'b0; FRAME = 1'b0; SDIN_L = 1'b0; SDIN_R = 1'b0; ACK = 1'b0;
    tick;
    tick;
    chk("rst_pdata_l", 32'(PDATA_L), 32'd0);
    chk("rst_pdata_r", 32'(PDATA_R), 32'd0);
    chk("rst_inready", 32'(InReady), 32'd0);
    chk("rst_busy",    32'(BUSY),    32'd0);
    chk("rst_overrun", 32'(OVERRUN), 32'd0);
    CLR = 1'b0;
    EN  = 1'b1;
    tick;

    // Basic word, EN held high; visible at k+16, ACK at k+18 clears at k+19.
    send_word(16'hA5C3, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t1_inready", 32'(InReady), 32'd1);
    chk_pop("t1");
    tick;
    tick;
    chk("t1_inready_k18", 32'(InReady), 32'd1);
    ACK = 1'b1;
    tick;
    ACK = 1'b0;
    chk("t1_inready_k19", 32'(InReady), 32'd0);

    // EN toggled every cycle: 16 EN cycles over 31 clocks.
    send_word(16'hA5C3, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t2_inready", 32'(InReady), 32'd1);
    chk_pop("t2");
    ACK = 1'b1;
    tick;
    ACK = 1'b0;
    chk("t2_ack", 32'(InReady), 32'd0);

    // Back-to-back with no ACK: second word dropped, OVERRUN sticks.
    send_word(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_pop("t3a");
    send_word(16'hFFFF, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_pdata_l", 32'(PDATA_L), 32'h0001);
    chk("t3_pdata_r", 32'(PDATA_R), 32'h0002);
    chk("t3_overrun", 32'(OVERRUN), 32'd1);
    chk("t3_inready", 32'(InReady), 32'd1);
    ACK = 1'b1;
    tick;
    ACK = 1'b0;
    tick;
    tick;
    chk("t3_inready_acked", 32'(InReady), 32'd0);
    chk("t3_overrun_sticky", 32'(OVERRUN), 32'd1);

    CLR = 1'b1;
    #1;
    chk("t4_clr_overrun", 32'(OVERRUN), 32'd0);
    tick;
    CLR = 1'b0;
    tick;

    // Second completion coincides with ACK: replaced, no overrun.
    send_word(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_pop("t4a");
    send_word(16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_inready", 32'(InReady), 32'd1);
    chk("t4_overrun", 32'(OVERRUN), 32'd0);
    chk_pop("t4b");

    // CLR after 7 bits of a word, holder still full.
    vl = 16'h5A5A;
    vr = 16'hC3C3;
    for (int i = 0; i < 7; i++) begin
      FRAME  = (i == 0);
      SDIN_L = vl[15-i];
      SDIN_R = vr[15-i];
      tick;
    end
    FRAME = 1'b0;
    chk("t5_busy_mid", 32'(BUSY), 32'd1);
    CLR = 1'b1;
    #1;
    chk("t5_pdata_l", 32'(PDATA_L), 32'd0);
    chk("t5_pdata_r", 32'(PDATA_R), 32'd0);
    chk("t5_inready", 32'(InReady), 32'd0);
    chk("t5_busy",    32'(BUSY),    32'd0);
    chk("t5_overrun", 32'(OVERRUN), 32'd0);
    tick;
    CLR = 1'b0;
    tick;
    send_word(16'h8001, 16'h7FFE, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_inready_new", 32'(InReady), 32'd1);
    chk_pop("t5");
    ACK = 1'b1;
    tick;
    ACK = 1'b0;

    // FRAME held high 40 cycles with a low/high blip at bit 5: one word only.
    vl = 16'h3C5A;
    vr = 16'hE71B;
    sb_q.push_back({vl, vr});
    busy_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      FRAME  = (c < 4) || (c >= 5);
      SDIN_L = (c < 16) ? vl[15 - (c % 16)] : 1'($urandom_range(0, 1));
      SDIN_R = (c < 16) ? vr[15 - (c % 16)] : 1'($urandom_range(0, 1));
      tick;
      if (c == 15) begin
        chk("t6_inready", 32'(InReady), 32'd1);
        chk_pop("t6");
      end
      if (c >= 16) busy_seen = busy_seen | BUSY;
    end
    FRAME = 1'b0;
    chk("t6_no_restart", 32'(busy_seen), 32'd0);
    chk("t6_overrun", 32'(OVERRUN), 32'd0);
    chk("t6_pdata_hold", {PDATA_L, PDATA_R}, {vl, vr});
    tick;

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
